// File: rtl/mem_access.sv
// rtl/mem_access.sv - LC-3 memory-access pipeline stage with data-memory sequencing FSM
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_mem,
    input  logic        mem_control_in,
    input  logic [1:0]  w_control_in,
    input  logic [15:0] ir_exec,
    input  logic [15:0] pcout,
    input  logic [15:0] aluout,
    input  logic [15:0] m_data,
    input  logic [2:0]  dr_in,
    input  logic [15:0] dmem_dout,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_din,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic        stall,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_dr,
    output logic [1:0]  wb_w_control
);

    typedef enum logic [2:0] {IDLE, IRD, ICAP, RD, RCAP, WR} state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_d, din_d, wb_data_d, m_data_q, m_data_d;
    logic        rd_d, wr_d, wb_valid_d, sti_q, sti_d;
    logic [2:0]  wb_dr_d, dr_q, dr_d;
    logic [1:0]  wb_wc_d, wc_q, wc_d;

    logic [3:0] opcode;
    logic       op_ld, op_ldr, op_ldi, op_st, op_str, op_sti;
    logic       is_mem, is_indirect, is_store;
    logic       unused_ir;

    assign opcode      = ir_exec[15:12];
    assign unused_ir   = &{1'b0, ir_exec[11:0]};
    assign op_ld       = (opcode == 4'b0010);
    assign op_ldr      = (opcode == 4'b0110);
    assign op_ldi      = (opcode == 4'b1010);
    assign op_st       = (opcode == 4'b0011);
    assign op_str      = (opcode == 4'b0111);
    assign op_sti      = (opcode == 4'b1011);
    assign is_mem      = mem_control_in & (op_ld | op_ldr | op_ldi | op_st | op_str | op_sti);
    assign is_indirect = op_ldi | op_sti;
    assign is_store    = op_st | op_str | op_sti;

    assign stall = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        addr_d     = dmem_addr;
        din_d      = dmem_din;
        rd_d       = dmem_rd;
        wr_d       = dmem_wr;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data;
        wb_dr_d    = wb_dr;
        wb_wc_d    = wb_w_control;
        m_data_d   = m_data_q;
        dr_d       = dr_q;
        wc_d       = wc_q;
        sti_d      = sti_q;
        case (state_q)
            IDLE: begin
                if (enable_mem) begin
                    m_data_d = m_data;
                    dr_d     = dr_in;
                    wc_d     = w_control_in;
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_dr_d    = dr_in;
                        wb_wc_d    = w_control_in;
                        case (w_control_in)
                            2'b00:   wb_data_d = aluout;
                            2'b10:   wb_data_d = pcout;
                            default: wb_data_d = 16'h0000;
                        endcase
                    end else begin
                        addr_d = pcout;
                        if (is_store && !is_indirect) begin
                            din_d   = m_data;
                            wr_d    = 1'b1;
                            state_d = WR;
                        end else begin
                            // STI starts like LDI: fetch the pointer first
                            rd_d    = 1'b1;
                            sti_d   = op_sti;
                            state_d = is_indirect ? IRD : RD;
                        end
                    end
                end
            end
            IRD: begin
                rd_d    = 1'b0;
                state_d = ICAP;
            end
            ICAP: begin
                addr_d = dmem_dout;
                if (sti_q) begin
                    din_d   = m_data_q;
                    wr_d    = 1'b1;
                    state_d = WR;
                end else begin
                    rd_d    = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                rd_d    = 1'b0;
                state_d = RCAP;
            end
            RCAP: begin
                wb_valid_d = 1'b1;
                wb_data_d  = dmem_dout;
                wb_dr_d    = dr_q;
                wb_wc_d    = wc_q;
                state_d    = IDLE;
            end
            WR: begin
                wr_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dmem_addr    <= 16'h0000;
            dmem_din     <= 16'h0000;
            dmem_rd      <= 1'b0;
            dmem_wr      <= 1'b0;
            wb_valid     <= 1'b0;
            wb_data      <= 16'h0000;
            wb_dr        <= 3'd0;
            wb_w_control <= 2'b00;
            m_data_q     <= 16'h0000;
            dr_q         <= 3'd0;
            wc_q         <= 2'b00;
            sti_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_addr    <= addr_d;
            dmem_din     <= din_d;
            dmem_rd      <= rd_d;
            dmem_wr      <= wr_d;
            wb_valid     <= wb_valid_d;
            wb_data      <= wb_data_d;
            wb_dr        <= wb_dr_d;
            wb_w_control <= wb_wc_d;
            m_data_q     <= m_data_d;
            dr_q         <= dr_d;
            wc_q         <= wc_d;
            sti_q        <= sti_d;
        end
    end

endmodule
